// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - parametrised multi-cycle ALU with valid/ready operand and result handshakes
//
// Purpose:
//   Logic, arithmetic, shift and compare operations finish in one cycle.
//   Unsigned multiply (shift-add) and divide (restoring) iterate one bit per
//   cycle for WIDTH cycles. The result and its flags are held until the
//   consumer takes them.
//
// Ports:
//   clk        clock, rising edge
//   rstn       synchronous active-low reset
//   in_valid   operands/opcode valid
//   in_ready   block accepts a new operation (IDLE only, low during reset)
//   A, B       operands, WIDTH bits
//   op         4-bit opcode
//   res        result, valid while out_valid
//   zero       res == 0
//   overflow   signed overflow for add/sub
//   div0       divide/remainder by zero
//   err        reserved opcode issued
//   out_valid  result and flags valid
//   out_ready  consumer takes the result
//   busy       high while multiplying or dividing

module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             overflow,
  output logic             div0,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;
  localparam logic [3:0] OP_MULHU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REMU  = 4'b1110;

  localparam int MSB = WIDTH - 1;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [3:0]         op_r;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // in_ready is the only combinational output: it must drop the moment
  // rstn is asserted, not one edge later.
  assign in_ready = (state == IDLE) && rstn;

  // ---------------------------------------------------------------- single-cycle datapath
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic             sc_div0;
  logic             sc_err;

  assign sum   = A + B;
  assign diff  = A - B;
  assign shamt = B[SHW-1:0];

  always_comb begin
    sc_res  = '0;
    sc_ovf  = 1'b0;
    sc_div0 = 1'b0;
    sc_err  = 1'b0;
    case (op)
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
      end
      OP_XOR:  sc_res = A ^ B;
      OP_NOR:  sc_res = ~(A | B);
      OP_SRL:  sc_res = A >> shamt;
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL:  sc_res = A << shamt;
      OP_SRA:  sc_res = $unsigned($signed(A) >>> shamt);
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
      // Only the divide-by-zero case of divu/remu ever takes this path;
      // the non-zero case is routed to the iterative divider.
      OP_DIVU: begin
        sc_res  = '1;
        sc_div0 = 1'b1;
      end
      OP_REMU: begin
        sc_res  = A;
        sc_div0 = 1'b1;
      end
      OP_MUL, OP_MULHU: sc_res = '0;
      default: sc_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- multiplier step
  // prod holds {partial product, remaining multiplier bits}; each step adds
  // the multiplicand into the upper half when the current multiplier bit is
  // set, then shifts the whole register right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, a_r};
  assign mul_next = prod[0] ? {mul_sum, prod[WIDTH-1:1]}
                            : {1'b0, prod[2*WIDTH-1:1]};

  // ---------------------------------------------------------------- divider step
  // Restoring division: quo starts as the dividend and is shifted out MSB
  // first into the partial remainder while quotient bits shift in at the
  // bottom. The partial remainder is always < divisor, so the trial
  // difference fits back into WIDTH bits.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign div_shift = {rem, quo[MSB]};
  assign div_trial = div_shift - {1'b0, b_r};
  assign div_ok    = ~div_trial[WIDTH];
  assign rem_next  = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_next  = {quo[WIDTH-2:0], div_ok};

  logic [WIDTH-1:0] mul_final;
  logic [WIDTH-1:0] div_final;

  assign mul_final = (op_r == OP_MUL)  ? mul_next[WIDTH-1:0] : mul_next[2*WIDTH-1:WIDTH];
  assign div_final = (op_r == OP_DIVU) ? quo_next            : rem_next;

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= '0;
      cnt       <= '0;
      prod      <= '0;
      quo       <= '0;
      rem       <= '0;
      res       <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      div0      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r  <= A;
            b_r  <= B;
            op_r <= op;
            cnt  <= CNT_LAST;
            if (op == OP_MUL || op == OP_MULHU) begin
              prod  <= {{WIDTH{1'b0}}, B};
              busy  <= 1'b1;
              state <= MUL;
            end else if ((op == OP_DIVU || op == OP_REMU) && (B != '0)) begin
              quo   <= A;
              rem   <= '0;
              busy  <= 1'b1;
              state <= DIV;
            end else begin
              res       <= sc_res;
              zero      <= (sc_res == '0);
              overflow  <= sc_ovf;
              div0      <= sc_div0;
              err       <= sc_err;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        MUL: begin
          prod <= mul_next;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            res       <= mul_final;
            zero      <= (mul_final == '0);
            overflow  <= 1'b0;
            div0      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end

        DIV: begin
          quo <= quo_next;
          rem <= rem_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            res       <= div_final;
            zero      <= (div_final == '0);
            overflow  <= 1'b0;
            div0      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end

        DONE: begin
          // No new accept here even with out_ready high; IDLE must be
          // visited first.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
